// File: rtl/fir_hp_pilot_pkg.sv
// Shared constants, state type, high-pass coefficient set and the dequantizer
// used by the pilot-path FIR stages.
package fir_hp_pilot_pkg;

  localparam int DATA_SIZE  = 32;
  localparam int ACC_SIZE   = 64;
  localparam int TAPS       = 32;
  localparam int QUANT_BITS = 10;

  localparam logic signed [ACC_SIZE-1:0] QUANT_VAL  = {{(ACC_SIZE-1){1'b0}}, 1'b1} << QUANT_BITS;
  localparam logic signed [ACC_SIZE-1:0] QUANT_MASK = QUANT_VAL - {{(ACC_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  // Symmetric Q10 high-pass: the taps sum to exactly zero, so DC is fully rejected.
  localparam logic signed [DATA_SIZE-1:0] HP_PILOT_COEFFS [TAPS] = '{
    -3,  -4,  -6,  -8, -11, -14, -18, -22,
    -27, -32, -37, -42, -46, -50, -53, 373,
    373, -53, -50, -46, -42, -37, -32, -27,
    -22, -18, -14, -11,  -8,  -6,  -4,  -3
  };

  // Divide by 2^QUANT_BITS truncating toward zero, like C integer division.
  function automatic logic signed [ACC_SIZE-1:0] dequantize(input logic signed [ACC_SIZE-1:0] value);
    if (value[ACC_SIZE-1])
      return (value + QUANT_MASK) >>> QUANT_BITS;
    else
      return value >>> QUANT_BITS;
  endfunction

endpackage

// File: rtl/fir_hp_pilot_if.sv
// FIFO-facing bundle of the pilot high-pass stage: upstream FWFT read port and
// downstream write port. master = filter side, slave = FIFO/test side.
interface fir_hp_pilot_if #(
  parameter int DATA_SIZE = fir_hp_pilot_pkg::DATA_SIZE
);

  logic                        in_empty;
  logic signed [DATA_SIZE-1:0] in_dout;
  logic                        in_rd_en;
  logic                        out_full;
  logic                        out_wr_en;
  logic signed [DATA_SIZE-1:0] out_din;

  modport master (
    input  in_empty,
    input  in_dout,
    input  out_full,
    output in_rd_en,
    output out_wr_en,
    output out_din
  );

  modport slave (
    output in_empty,
    output in_dout,
    output out_full,
    input  in_rd_en,
    input  out_wr_en,
    input  out_din
  );

endinterface

// File: rtl/fir_hp_pilot.sv
// Sequential single-MAC FIR high-pass removing DC from the squared pilot.
// Define FIR_HP_PILOT_SAT_EN to saturate the output instead of wrapping.
module fir_hp_pilot
  import fir_hp_pilot_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  fir_hp_pilot_if.master bus
);

  localparam int IDX_W = $clog2(TAPS);

  state_t                       state;
  logic [IDX_W-1:0]             idx;
  logic signed [ACC_SIZE-1:0]   acc;
  logic signed [DATA_SIZE-1:0]  hist [TAPS];
  logic signed [DATA_SIZE-1:0]  last_din;
  logic signed [2*DATA_SIZE-1:0] product;
  logic signed [DATA_SIZE-1:0]  result;
  logic                         pop;
  logic                         push;

  // FWFT handshake: strobes are decoded from state so a pop or push lands in
  // the same cycle the FIFO flag is seen, and never while reset is held.
  assign pop  = reset && (state == S_IDLE) && !bus.in_empty;
  assign push = reset && (state == S_OUT)  && !bus.out_full;

  assign bus.in_rd_en  = pop;
  assign bus.out_wr_en = push;
  assign bus.out_din   = push ? result : last_din;

  assign product = HP_PILOT_COEFFS[idx] * hist[idx];

`ifdef FIR_HP_PILOT_SAT_EN
  localparam logic signed [ACC_SIZE-1:0] SAT_MAX = ACC_SIZE'({1'b0, {(DATA_SIZE-1){1'b1}}});
  localparam logic signed [ACC_SIZE-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_SIZE-1:0] deq;
  logic                       clip_hi;
  logic                       clip_lo;
  logic                       sat_seen;

  assign deq     = dequantize(acc);
  assign clip_hi = deq > SAT_MAX;
  assign clip_lo = deq < SAT_MIN;
  assign result  = clip_hi ? SAT_MAX[DATA_SIZE-1:0] :
                   clip_lo ? SAT_MIN[DATA_SIZE-1:0] : deq[DATA_SIZE-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      sat_seen <= 1'b0;
    else if (push && (clip_hi || clip_lo))
      sat_seen <= 1'b1;
  end
`else
  assign result = DATA_SIZE'(dequantize(acc));
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      acc      <= '0;
      last_din <= '0;
      for (int k = 0; k < TAPS; k++)
        hist[k] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            hist[0] <= bus.in_dout;
            for (int k = 1; k < TAPS; k++)
              hist[k] <= hist[k-1];
            acc   <= '0;
            idx   <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + ACC_SIZE'(product);
          if (idx == IDX_W'(TAPS - 1)) begin
            idx   <= '0;
            state <= S_OUT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_OUT: begin
          if (push) begin
            last_din <= result;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_hp_pilot.sv
// Self-checking bench for fir_hp_pilot: FWFT FIFO models on both sides and a
// direct-form convolution reference with C-style truncating division.
module tb_fir_hp_pilot;

  localparam int NTAPS = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;

  fir_hp_pilot_if bus ();

  fir_hp_pilot dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  int proto_err  = 0;

  // Independent copy of the expected high-pass taps (Q10).
  int h_ref [NTAPS] = '{
    -3,  -4,  -6,  -8, -11, -14, -18, -22,
    -27, -32, -37, -42, -46, -50, -53, 373,
    373, -53, -50, -46, -42, -37, -32, -27,
    -22, -18, -14, -11,  -8,  -6,  -4,  -3
  };

  // Upstream FWFT FIFO model
  logic [31:0] fifo_mem [0:2047];
  int head = 0;
  int tail = 0;
  bit rd_pending = 1'b0;

  assign bus.in_empty = (head == tail);
  assign bus.in_dout  = fifo_mem[head[10:0]];

  logic [31:0] obs_q [$];
  int          obs_cycle [$];
  int          pop_cycle [$];
  longint      ref_hist [$];

  // Strobes are sampled mid-cycle, where they describe the coming clock edge.
  always @(negedge clock) begin
    if (bus.in_rd_en === 1'b1) begin
      pop_cycle.push_back(cycle);
      rd_pending = 1'b1;
    end
    if (bus.out_wr_en === 1'b1) begin
      obs_q.push_back(bus.out_din);
      obs_cycle.push_back(cycle);
    end
    if ((bus.in_rd_en && bus.in_empty) || (bus.out_wr_en && bus.out_full) ||
        (bus.in_rd_en && bus.out_wr_en))
      proto_err++;
  end

  always @(posedge clock) begin
    cycle++;
    if (rd_pending) begin
      rd_pending = 1'b0;
      #1 head++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // y[n] = sum h[k]*x[n-k], then divide by 1024 truncating toward zero, keep 32 bits.
  function automatic logic [31:0] ref_push(input logic [31:0] sample);
    longint acc_l = 0;
    ref_hist.push_front(longint'($signed(sample)));
    if (ref_hist.size() > NTAPS)
      void'(ref_hist.pop_back());
    for (int k = 0; k < ref_hist.size(); k++)
      acc_l += longint'(h_ref[k]) * ref_hist[k];
    return 32'(acc_l / 1024);
  endfunction

  task automatic applyStimulus(input logic [31:0] s);
    fifo_mem[tail[10:0]] = s;
    tail++;
  endtask

  task automatic wait_outputs(input int n, input int budget, output bit ok);
    int c = 0;
    while (obs_q.size() < n && c < budget) begin
      @(posedge clock);
      c++;
    end
    @(negedge clock);
    ok = (obs_q.size() >= n);
  endtask

  task automatic clear_logs();
    obs_q.delete();
    obs_cycle.delete();
    pop_cycle.delete();
  endtask

  task automatic test_reset();
    applyStimulus(32'h0000_1234);
    repeat (2) @(negedge clock);
    compared++;
    if (bus.in_rd_en !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_rd_en: got %b expected 0", bus.in_rd_en);
    end
    compared++;
    if (bus.out_wr_en !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_wr_en: got %b expected 0", bus.out_wr_en);
    end
    compared++;
    if (bus.out_din !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_din: got %h expected 0", bus.out_din);
    end
    head = 0;
    tail = 0;
    @(posedge clock);
    #1 reset = 1'b1;
    clear_logs();
    repeat (5) @(posedge clock);
    @(negedge clock);
    compared++;
    if (pop_cycle.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL idle_no_pop: got %0d pops expected 0", pop_cycle.size());
    end
  endtask

  task automatic test_impulse();
    bit ok;
    clear_logs();
    @(posedge clock);
    #1;
    for (int k = 0; k < NTAPS; k++) begin
      void'(ref_push((k == 0) ? 32'd1024 : 32'd0));
      applyStimulus((k == 0) ? 32'd1024 : 32'd0);
    end
    wait_outputs(NTAPS, NTAPS * 40, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL impulse_count: got %0d expected %0d", obs_q.size(), NTAPS);
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        compared++;
        if (obs_q[k] !== 32'(h_ref[k])) begin
          mismatched++;
          $display("[TB] FAIL impulse[%0d]: got %0d expected %0d", k, $signed(obs_q[k]), h_ref[k]);
        end
      end
      compared++;
      if (obs_cycle[0] - pop_cycle[0] !== NTAPS + 1) begin
        mismatched++;
        $display("[TB] FAIL impulse_latency: got %0d expected %0d", obs_cycle[0] - pop_cycle[0], NTAPS + 1);
      end
      compared++;
      if (obs_cycle[1] - obs_cycle[0] !== NTAPS + 2) begin
        mismatched++;
        $display("[TB] FAIL impulse_period: got %0d expected %0d", obs_cycle[1] - obs_cycle[0], NTAPS + 2);
      end
    end
  endtask

  task automatic test_dc_rejection();
    logic [31:0] exp_q [$];
    bit ok;
    int v;
    clear_logs();
    @(posedge clock);
    #1;
    for (int k = 0; k < 200; k++) begin
      exp_q.push_back(ref_push(32'd1024));
      applyStimulus(32'd1024);
    end
    wait_outputs(200, 200 * 40, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL dc_count: got %0d expected 200", obs_q.size());
    end else begin
      for (int k = 0; k < 200; k++) begin
        compared++;
        if (obs_q[k] !== exp_q[k]) begin
          mismatched++;
          $display("[TB] FAIL dc[%0d]: got %0d expected %0d", k, $signed(obs_q[k]), $signed(exp_q[k]));
        end
        if (k >= NTAPS) begin
          v = $signed(obs_q[k]);
          compared++;
          if (v > 1 || v < -1) begin
            mismatched++;
            $display("[TB] FAIL dc_settled[%0d]: got %0d expected within +/-1 of 0", k, v);
          end
        end
      end
    end
  endtask

  task automatic test_negative_rounding();
    logic [31:0] exp_q [$];
    bit ok;
    @(posedge clock);
    #1 reset = 1'b0;
    ref_hist.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    clear_logs();
    for (int k = 0; k < NTAPS; k++) begin
      exp_q.push_back(ref_push((k == 0) ? 32'hFFFF_FFFF : 32'd0));
      applyStimulus((k == 0) ? 32'hFFFF_FFFF : 32'd0);
    end
    wait_outputs(NTAPS, NTAPS * 40, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL neground_count: got %0d expected %0d", obs_q.size(), NTAPS);
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        compared++;
        if (obs_q[k] !== exp_q[k]) begin
          mismatched++;
          $display("[TB] FAIL neground[%0d]: got %0d expected %0d", k, $signed(obs_q[k]), $signed(exp_q[k]));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q [$];
    logic [31:0] s;
    bit ok;
    int stall_bad = 0;
    clear_logs();
    @(posedge clock);
    #1 bus.out_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s = $urandom;
      exp_q.push_back(ref_push(s));
      applyStimulus(s);
    end
    repeat (NTAPS + 6) @(posedge clock);
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (bus.out_wr_en !== 1'b0 || bus.in_rd_en !== 1'b0)
        stall_bad++;
    end
    compared++;
    if (stall_bad !== 0) begin
      mismatched++;
      $display("[TB] FAIL stall_quiet: got %0d active cycles expected 0", stall_bad);
    end
    @(posedge clock);
    #1 bus.out_full = 1'b0;
    @(negedge clock);
    compared++;
    if (bus.out_wr_en !== 1'b1 || bus.out_din !== exp_q[0]) begin
      mismatched++;
      $display("[TB] FAIL stall_release: got wr=%b din=%h expected wr=1 din=%h", bus.out_wr_en, bus.out_din, exp_q[0]);
    end
    wait_outputs(3, 3 * 40, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL stall_count: got %0d expected 3", obs_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        compared++;
        if (obs_q[k] !== exp_q[k]) begin
          mismatched++;
          $display("[TB] FAIL stall[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    int c = 0;
    clear_logs();
    @(posedge clock);
    #1 applyStimulus($urandom);
    while (pop_cycle.size() == 0 && c < 10) begin
      @(posedge clock);
      c++;
    end
    compared++;
    if (pop_cycle.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL midmac_pop: got no pop expected 1");
    end
    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    ref_hist.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (NTAPS + 10) @(posedge clock);
    @(negedge clock);
    compared++;
    if (obs_q.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL midmac_no_write: got %0d writes expected 0", obs_q.size());
    end
    test_impulse();
  endtask

  task automatic test_random_stream();
    logic [31:0] exp_q [$];
    logic [31:0] s;
    int c = 0;
    clear_logs();
    @(posedge clock);
    #1;
    for (int k = 0; k < 60; k++) begin
      s = $urandom;
      exp_q.push_back(ref_push(s));
      applyStimulus(s);
    end
    while (obs_q.size() < 60 && c < 60 * 80) begin
      @(posedge clock);
      #1 bus.out_full = ($urandom_range(0, 3) == 0);
      c++;
    end
    bus.out_full = 1'b0;
    @(negedge clock);
    compared++;
    if (obs_q.size() !== 60) begin
      mismatched++;
      $display("[TB] FAIL random_count: got %0d expected 60", obs_q.size());
    end else begin
      for (int k = 0; k < 60; k++) begin
        compared++;
        if (obs_q[k] !== exp_q[k]) begin
          mismatched++;
          $display("[TB] FAIL random[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic checkOutput();
    compared++;
    if (proto_err !== 0) begin
      mismatched++;
      $display("[TB] FAIL protocol: got %0d violations expected 0", proto_err);
    end
  endtask

  initial begin
    bus.out_full = 1'b0;
    $display("[TB] starting fir_hp_pilot bench");
    test_reset();
    test_impulse();
    test_dc_rejection();
    test_negative_rounding();
    test_backpressure();
    test_reset_mid_mac();
    test_random_stream();
    checkOutput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fir_hp_pilot.md
Name: fir_hp_pilot

Overview:
- Sequential single-MAC FIR high-pass filter.
- Sits directly downstream of the pilot squarer (multiply stage). Consumes the squared pilot samples from that stage's output FIFO and removes the DC term so only the 38 kHz carrier remains.
- FIFO-to-FIFO interfaces on both sides. Fixed-point data is quantized with QUANT_BITS fraction bits.

Parameters:
- DATA_SIZE, 32, sample width (signed).
- ACC_SIZE, 64, accumulator width (signed).
- TAPS, 32, number of filter taps.
- QUANT_BITS, 10, fraction bits; one quantized unit is 1<<QUANT_BITS.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_empty  in  1  upstream FIFO empty
- in_dout  in  DATA_SIZE  upstream FIFO head data (first-word-fall-through: valid whenever !in_empty)
- in_rd_en  out  1  pop upstream FIFO
- out_full  in  1  downstream FIFO full
- out_wr_en  out  1  push downstream FIFO
- out_din  out  DATA_SIZE  filtered sample

Behaviour:
- Reset (reset=0, async):
  - state=S_IDLE, tap index=0, acc=0.
  - All TAPS history registers cleared to 0.
  - in_rd_en=0, out_wr_en=0, out_din=0.
- Coefficients: constant signed DATA_SIZE Q10 values h[0..TAPS-1], taken from the package.
- S_IDLE:
  - If !in_empty: in_rd_en=1 for exactly one cycle.
  - History shifts in the same cycle: x[0]<=in_dout, x[k]<=x[k-1].
  - acc<=0, idx<=0, go to S_MAC.
  - Else remain in S_IDLE with in_rd_en=0.
- S_MAC:
  - Each cycle: acc += h[idx]*x[idx]. Product is full 2*DATA_SIZE signed, sign-extended/truncated to ACC_SIZE.
  - idx increments each cycle. After idx==TAPS-1, go to S_OUT.
  - Takes exactly TAPS cycles. No FIFO activity during S_MAC.
- S_OUT:
  - Result computed combinationally from acc: dequantize by divide-by-2^QUANT_BITS, truncating toward zero (C semantics):
    - acc<0: (acc + 2^QUANT_BITS - 1) >>> QUANT_BITS
    - else: acc >>> QUANT_BITS
  - Keep the low DATA_SIZE bits (wrap) unless the optional feature is enabled.
  - If !out_full: out_wr_en=1 for one cycle with out_din=result, then go to S_IDLE.
  - If out_full: hold in S_OUT, out_wr_en=0, acc stable. No new pops while stalled (backpressure propagates upstream).
- Timing:
  - Pop to push latency is TAPS+1 cycles when unstalled.
  - Max throughput is one sample per TAPS+2 cycles.
- out_din holds its last written value between writes.
- in_rd_en and out_wr_en are never high in the same cycle.
- in_rd_en is never asserted when in_empty=1; out_wr_en is never asserted when out_full=1.
- Reset mid-operation (any state):
  - Immediate return to reset values; history cleared.
  - A partial accumulation is discarded and never written.
- End of stream: no flush. The block idles in S_IDLE with history retained.

Optional Feature:
- Macro: FIR_HP_PILOT_SAT_EN.
- Defined: the dequantized result saturates to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1] before output. A sticky output-free internal flag sat_seen is set on any clip; it is cleared only by reset.
- Undefined: the low DATA_SIZE bits are taken (two's-complement wrap). No sat_seen logic is generated.

Decomposition:
- Package fir_hp_pilot_pkg holds:
  - TAPS, QUANT_BITS, QUANT_VAL
  - the state enum typedef (S_IDLE, S_MAC, S_OUT)
  - the constant coefficient array HP_PILOT_COEFFS[TAPS]
  - a dequantize function shared with the multiply stage
- Core is one module.
- Natural wrapper sub-module: fir_hp_pilot_top, instantiating the input FIFO, the core and the output FIFO, with the same FIFO-facing ports as multiply_top so the two stages chain directly.

Test Plan:
- Impulse:
  - Stimulus: 1024 (1.0 Q10) followed by TAPS-1 zeros.
  - Expected: outputs equal h[0], h[1], ..., h[TAPS-1] exactly.
  - Expected: the first out_wr_en comes TAPS+1 cycles after the first in_rd_en.
- DC rejection:
  - Stimulus: 200 samples of constant 1024.
  - Expected: after TAPS samples, outputs equal (1024*sum(h))/1024 truncated toward zero, i.e. within ±1 of 0 for the HP set.
- Negative rounding:
  - Stimulus: single sample -1 then zeros.
  - Expected: each output equals (-h[k])/1024 truncated toward zero, e.g. h[k]=500 → 0, never -1.
- Backpressure:
  - Stimulus: out_full held 1 for 100 cycles after the first result is ready.
  - Expected: out_wr_en=0 and no in_rd_en during the stall.
  - Expected: the result is written on the first cycle out_full=0; sequence matches the golden file bit-exact.
- Reset mid-MAC:
  - Stimulus: assert reset 5 cycles into S_MAC, then release.
  - Expected: no write occurs; next impulse output matches the impulse test, proving history was cleared.
- Golden file:
  - Stimulus: stream the multiply-stage output text file.
  - Expected: all outputs match the C reference hp_pilot output; 0 errors.
  - Repeat with FIR_HP_PILOT_SAT_EN defined, driving 0x7FFFFFFF inputs → outputs clip to 0x7FFFFFFF/0x80000000 and sat_seen=1.
